// File: rtl/mgr_desc_pkg.sv
// Shared codes, widths and decode helpers for the descriptor receiver.
// ST_DROP exists only when MRC_DESC_RX_PROTOCOL_CHECK_EN is defined.
package mgr_desc_pkg;

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    localparam logic [7:0] OPT_NOP        = 8'd0;
    localparam logic [7:0] OPT_TGT_ADDR   = 8'd1;
    localparam logic [7:0] OPT_NUM_LANES  = 8'd2;
    localparam logic [7:0] OPT_TXFER_TYPE = 8'd3;

    localparam int OPT_TYPE_W  = 8;
    localparam int OPT_VALUE_W = 24;
    localparam int LANES_W     = 6;
    localparam int TYPE_W      = 4;
    localparam int NUM_PAIRS   = 3;
    localparam int FIFO_DEPTH  = 2;
    localparam int MAX_LANES   = 32;

    typedef struct packed {
        logic [OPT_VALUE_W-1:0] addr;
        logic [LANES_W-1:0]     lanes;
        logic [TYPE_W-1:0]      ttype;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    localparam desc_t DESC_DEFAULT = '{addr: '0, lanes: 6'd1, ttype: '0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
        , ST_DROP
`endif
    } state_e;

    // Compare on the full value so large counts cannot alias into [5:0].
    function automatic logic [LANES_W-1:0] sat_lanes(input logic [OPT_VALUE_W-1:0] v);
        if (v == '0)
            return LANES_W'(1);
        else if (v > OPT_VALUE_W'(MAX_LANES))
            return LANES_W'(MAX_LANES);
        else
            return v[LANES_W-1:0];
    endfunction

    function automatic desc_t apply_beat(
        input desc_t                                   base,
        input logic [NUM_PAIRS-1:0][OPT_TYPE_W-1:0]    t,
        input logic [NUM_PAIRS-1:0][OPT_VALUE_W-1:0]   v
    );
        desc_t d;
        d = base;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            case (t[i])
                OPT_TGT_ADDR:   d.addr  = v[i];
                OPT_NUM_LANES:  d.lanes = sat_lanes(v[i]);
                OPT_TXFER_TYPE: d.ttype = v[i][TYPE_W-1:0];
                default:        ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/mrc_desc_fifo.sv
// Small synchronous FIFO for decoded descriptors; head entry is shown directly.
module mrc_desc_fifo
    import mgr_desc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = DESC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         full_next_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign full_o      = (cnt_q == CW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign full_next_o = (cnt_d == CW'(DEPTH));

endmodule

// File: rtl/mrc_desc_rx.sv
// Descriptor beat receiver: assembles option pairs into descriptors and queues them.
// Define MRC_DESC_RX_PROTOCOL_CHECK_EN to enable framing error detection and DROP.
module mrc_desc_rx
    import mgr_desc_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset_poll,
    input  logic                                  wud__mrc__valid,
    output logic                                  mrc__wud__ready,
    input  logic [1:0]                            wud__mrc__cntl,
    input  logic [NUM_PAIRS-1:0][OPT_TYPE_W-1:0]  wud__mrc__option_type,
    input  logic [NUM_PAIRS-1:0][OPT_VALUE_W-1:0] wud__mrc__option_value,
    output logic                                  mrc__rd__valid,
    input  logic                                  rd__mrc__ready,
    output logic [OPT_VALUE_W-1:0]                mrc__rd__addr,
    output logic [LANES_W-1:0]                    mrc__rd__num_lanes,
    output logic [TYPE_W-1:0]                     mrc__rd__txfer_type,
    output logic                                  mrc__rd__err
);

    state_e state_q;
    desc_t  acc_q;
    logic   ready_q;
    desc_t  beat_fresh;
    desc_t  beat_cont;
    desc_t  push_data;
    desc_t  fifo_dout;
    logic   push;
    logic   pop;
    logic   accept;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_full_next;

    assign accept     = wud__mrc__valid && ready_q;
    assign beat_fresh = apply_beat(DESC_DEFAULT, wud__mrc__option_type, wud__mrc__option_value);
    assign beat_cont  = apply_beat(acc_q, wud__mrc__option_type, wud__mrc__option_value);
    assign pop        = mrc__rd__valid && rd__mrc__ready;

    // The descriptor must enter the FIFO on the same edge that accepts its last beat.
    always_comb begin
        push      = 1'b0;
        push_data = beat_fresh;
        if (accept && !fifo_full) begin
            case (state_q)
                ST_IDLE:    push = (wud__mrc__cntl == CNTL_SOM_EOM);
                ST_COLLECT: begin
                    if (wud__mrc__cntl == CNTL_EOM) begin
                        push      = 1'b1;
                        push_data = beat_cont;
                    end else if (wud__mrc__cntl == CNTL_SOM_EOM) begin
                        push = 1'b1;
                    end
                end
                default:    ;
            endcase
        end
    end

`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
    logic err_q;
`endif

    always_ff @(posedge clk or posedge reset_poll) begin
        if (reset_poll) begin
            state_q <= ST_IDLE;
            acc_q   <= DESC_DEFAULT;
            ready_q <= 1'b0;
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ready_q <= !fifo_full_next;
            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        case (wud__mrc__cntl)
                            CNTL_SOM: begin
                                acc_q   <= beat_fresh;
                                state_q <= ST_COLLECT;
                            end
                            CNTL_SOM_EOM: acc_q <= beat_fresh;
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
                            CNTL_MOM: begin
                                err_q   <= 1'b1;
                                state_q <= ST_DROP;
                            end
                            // A stray EOM already closes its message; nothing left to drop.
                            CNTL_EOM: err_q <= 1'b1;
`endif
                            default: ;
                        endcase
                    end
                    ST_COLLECT: begin
                        case (wud__mrc__cntl)
                            CNTL_MOM: acc_q <= beat_cont;
                            CNTL_EOM: state_q <= ST_IDLE;
                            CNTL_SOM: begin
                                acc_q <= beat_fresh;
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
                                err_q <= 1'b1;
`endif
                            end
                            default: begin
                                acc_q   <= beat_fresh;
                                state_q <= ST_IDLE;
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
                                err_q   <= 1'b1;
`endif
                            end
                        endcase
                    end
`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
                    ST_DROP: if (wud__mrc__cntl == CNTL_EOM) state_q <= ST_IDLE;
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
    assign mrc__rd__err = err_q;
`else
    assign mrc__rd__err = 1'b0;
`endif

    mrc_desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DESC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset_poll),
        .push_i      (push),
        .data_i      (push_data),
        .pop_i       (pop),
        .data_o      (fifo_dout),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .full_next_o (fifo_full_next)
    );

    assign mrc__wud__ready     = ready_q;
    assign mrc__rd__valid      = !fifo_empty;
    assign mrc__rd__addr       = fifo_dout.addr;
    assign mrc__rd__num_lanes  = fifo_dout.lanes;
    assign mrc__rd__txfer_type = fifo_dout.ttype;

endmodule

// File: tb/tb_mrc_desc_rx.sv
// Directed bench for mrc_desc_rx: vector table of single-beat descriptors plus
// hand-written multi-beat, backpressure, reset and framing sequences.
module tb_mrc_desc_rx;

    logic              clk;
    logic              reset_poll;
    logic              wud__mrc__valid;
    logic              mrc__wud__ready;
    logic [1:0]        wud__mrc__cntl;
    logic [2:0][7:0]   wud__mrc__option_type;
    logic [2:0][23:0]  wud__mrc__option_value;
    logic              mrc__rd__valid;
    logic              rd__mrc__ready;
    logic [23:0]       mrc__rd__addr;
    logic [5:0]        mrc__rd__num_lanes;
    logic [3:0]        mrc__rd__txfer_type;
    logic              mrc__rd__err;

    localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SOE = 2'b11;

`ifdef MRC_DESC_RX_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  t0; logic [23:0] v0;
        logic [7:0]  t1; logic [23:0] v1;
        logic [7:0]  t2; logic [23:0] v2;
        logic [23:0] ea;
        logic [5:0]  el;
        logic [3:0]  et;
    } vec_t;

    vec_t vecs[8];
    int n_checks = 0;
    int n_fail   = 0;

    mrc_desc_rx dut (
        .clk                    (clk),
        .reset_poll             (reset_poll),
        .wud__mrc__valid        (wud__mrc__valid),
        .mrc__wud__ready        (mrc__wud__ready),
        .wud__mrc__cntl         (wud__mrc__cntl),
        .wud__mrc__option_type  (wud__mrc__option_type),
        .wud__mrc__option_value (wud__mrc__option_value),
        .mrc__rd__valid         (mrc__rd__valid),
        .rd__mrc__ready         (rd__mrc__ready),
        .mrc__rd__addr          (mrc__rd__addr),
        .mrc__rd__num_lanes     (mrc__rd__num_lanes),
        .mrc__rd__txfer_type    (mrc__rd__txfer_type),
        .mrc__rd__err           (mrc__rd__err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [23:0] a, input logic [5:0] l,
                             input logic [3:0] t);
        check({tag, ".valid"}, 32'(mrc__rd__valid), 32'd1);
        check({tag, ".addr"},  32'(mrc__rd__addr), 32'(a));
        check({tag, ".lanes"}, 32'(mrc__rd__num_lanes), 32'(l));
        check({tag, ".type"},  32'(mrc__rd__txfer_type), 32'(t));
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] t0, input logic [23:0] v0,
                         input logic [7:0] t1, input logic [23:0] v1,
                         input logic [7:0] t2, input logic [23:0] v2);
        wud__mrc__valid        = 1'b1;
        wud__mrc__cntl         = c;
        wud__mrc__option_type  = {t2, t1, t0};
        wud__mrc__option_value = {v2, v1, v0};
    endtask

    // Present a beat and hold it until the edge that accepts it (bounded wait).
    task automatic send(input logic [1:0] c, input logic [7:0] t0, input logic [23:0] v0,
                        input logic [7:0] t1, input logic [23:0] v1,
                        input logic [7:0] t2, input logic [23:0] v2);
        int n;
        drive(c, t0, v0, t1, v1, t2, v2);
        n = 0;
        while (!mrc__wud__ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mrc__wud__ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: ready got 0, expected 1");
        end
        @(posedge clk); #1;
        wud__mrc__valid = 1'b0;
    endtask

    task automatic pop_one();
        rd__mrc__ready = 1'b1;
        @(posedge clk); #1;
        rd__mrc__ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(mrc__wud__ready), 32'd0);
        check({tag, ".valid"}, 32'(mrc__rd__valid), 32'd0);
        check({tag, ".addr"},  32'(mrc__rd__addr), 32'd0);
        check({tag, ".lanes"}, 32'(mrc__rd__num_lanes), 32'd0);
        check({tag, ".type"},  32'(mrc__rd__txfer_type), 32'd0);
        check({tag, ".err"},   32'(mrc__rd__err), 32'd0);
    endtask

    initial begin
        //            t0  v0         t1  v1         t2  v2         addr       lanes  type
        vecs[0] = '{8'd1, 24'h000100, 8'd2, 24'd4,     8'd3, 24'd2,    24'h000100, 6'd4,  4'd2};
        vecs[1] = '{8'd2, 24'd0,      8'd0, 24'h77,    8'd0, 24'd0,    24'h0,      6'd1,  4'd0};
        vecs[2] = '{8'd2, 24'd40,     8'd0, 24'd0,     8'd0, 24'd0,    24'h0,      6'd32, 4'd0};
        vecs[3] = '{8'd2, 24'd32,     8'd1, 24'hFFFFFF, 8'd9, 24'd5,   24'hFFFFFF, 6'd32, 4'd0};
        vecs[4] = '{8'd2, 24'h000101, 8'd3, 24'h39,    8'd1, 24'h5A5A5A, 24'h5A5A5A, 6'd32, 4'd9};
        vecs[5] = '{8'd1, 24'hAAAAAA, 8'd1, 24'h123456, 8'd5, 24'd7,   24'h123456, 6'd1,  4'd0};
        vecs[6] = '{8'd3, 24'h1F,     8'd2, 24'd33,    8'd3, 24'd6,    24'h0,      6'd32, 4'd6};
        vecs[7] = '{8'd2, 24'd1,      8'd2, 24'd31,    8'd0, 24'd0,    24'h0,      6'd31, 4'd0};

        reset_poll             = 1'b1;
        wud__mrc__valid        = 1'b0;
        wud__mrc__cntl         = 2'b00;
        wud__mrc__option_type  = '0;
        wud__mrc__option_value = '0;
        rd__mrc__ready         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        reset_poll = 1'b0;
        #1;
        check("ready_before_edge", 32'(mrc__wud__ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(mrc__wud__ready), 32'd1);

        // Single-beat descriptors from the table.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d.pre_valid", i), 32'(mrc__rd__valid), 32'd0);
            send(SOE, vecs[i].t0, vecs[i].v0, vecs[i].t1, vecs[i].v1, vecs[i].t2, vecs[i].v2);
            check_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].el, vecs[i].et);
            pop_one();
            check($sformatf("vec%0d.post_pop", i), 32'(mrc__rd__valid), 32'd0);
        end

        // Multi-beat descriptor: later beat overrides the address.
        send(SOM, 8'd1, 24'h10, 8'd0, 24'd0, 8'd0, 24'd0);
        check("multi.som_valid", 32'(mrc__rd__valid), 32'd0);
        send(MOM, 8'd1, 24'h20, 8'd0, 24'd0, 8'd0, 24'd0);
        check("multi.mom_valid", 32'(mrc__rd__valid), 32'd0);
        send(EOM, 8'd2, 24'd8, 8'd0, 24'd0, 8'd0, 24'd0);
        check_out("multi", 24'h20, 6'd8, 4'd0);
        pop_one();

        // Backpressure: two descriptors fill the FIFO, third waits.
        send(SOE, 8'd1, 24'd1, 8'd0, 24'd0, 8'd0, 24'd0);
        check("bp.ready_after1", 32'(mrc__wud__ready), 32'd1);
        send(SOE, 8'd1, 24'd2, 8'd0, 24'd0, 8'd0, 24'd0);
        check("bp.ready_full", 32'(mrc__wud__ready), 32'd0);
        drive(SOE, 8'd1, 24'd3, 8'd0, 24'd0, 8'd0, 24'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp.hold%0d.ready", k), 32'(mrc__wud__ready), 32'd0);
            check($sformatf("bp.hold%0d.addr", k), 32'(mrc__rd__addr), 32'd1);
        end
        rd__mrc__ready = 1'b1;
        @(posedge clk); #1;
        check("bp.ready_after_pop", 32'(mrc__wud__ready), 32'd1);
        check_out("bp.second", 24'd2, 6'd1, 4'd0);
        @(posedge clk); #1;
        // Push and pop on the same edge with one entry held.
        wud__mrc__valid = 1'b0;
        rd__mrc__ready  = 1'b0;
        check_out("bp.third", 24'd3, 6'd1, 4'd0);
        check("bp.ready_pushpop", 32'(mrc__wud__ready), 32'd1);
        pop_one();
        check("bp.drained", 32'(mrc__rd__valid), 32'd0);

        // Reset in the middle of a descriptor with one entry queued.
        send(SOE, 8'd1, 24'h77, 8'd0, 24'd0, 8'd0, 24'd0);
        send(SOM, 8'd1, 24'h55, 8'd0, 24'd0, 8'd0, 24'd0);
        check("rst.queued_addr", 32'(mrc__rd__addr), 32'h77);
        #2;
        reset_poll = 1'b1;
        #1;
        check_reset_outputs("rst.async");
        @(posedge clk); #1;
        reset_poll = 1'b0;
        @(posedge clk); #1;
        send(EOM, 8'd2, 24'd8, 8'd0, 24'd0, 8'd0, 24'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.no_output", 32'(mrc__rd__valid), 32'd0);
        check("rst.stray_eom_err", 32'(mrc__rd__err), 32'(EXP_ERR));

        reset_poll = 1'b1;
        #1;
        check("rst2.err_clear", 32'(mrc__rd__err), 32'd0);
        @(posedge clk); #1;
        reset_poll = 1'b0;
        @(posedge clk); #1;

        // Framing: MOM in IDLE then EOM, then a well-formed single beat.
        send(MOM, 8'd1, 24'h999, 8'd0, 24'd0, 8'd0, 24'd0);
        send(EOM, 8'd1, 24'h888, 8'd0, 24'd0, 8'd0, 24'd0);
        check("frm.no_output", 32'(mrc__rd__valid), 32'd0);
        send(SOE, 8'd1, 24'hABC, 8'd2, 24'd3, 8'd0, 24'd0);
        check_out("frm", 24'hABC, 6'd3, 4'd0);
        check("frm.err", 32'(mrc__rd__err), 32'(EXP_ERR));
        pop_one();
        check("frm.only_one", 32'(mrc__rd__valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
